// File: rtl/fwd_scoreboard.sv
// Destination-tag scoreboard producing D/E forward selects and the decode stall.
// Optional HI/LO busy tracker enabled by defining FWD_MDU_EN.
module fwd_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int NSRC    = 2,
  parameter int RW      = 5,
  parameter int SW      = 2,
  parameter int MDU_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC*RW-1:0] src_reg,
  input  logic [NSRC-1:0]    src_use,
  input  logic [NSRC-1:0]    src_need_e,
  input  logic               iss_we,
  input  logic [RW-1:0]      iss_dst,
  input  logic [SW-1:0]      iss_rdy,
  input  logic               flush,
  input  logic               hilo_use,
  input  logic               mdu_start,
  output logic [NSRC*SW-1:0] fwd_sel_d,
  output logic [NSRC*SW-1:0] fwd_sel_e,
  output logic               stall,
  output logic               mdu_busy
);

  logic              v_q   [1:NSTAGE];
  logic [RW-1:0]     dst_q [1:NSTAGE];
  logic [SW-1:0]     rdy_q [1:NSTAGE];
  logic              v1_d;
  logic [NSRC*SW-1:0] fwd_sel_e_q, fwd_sel_e_d;
  logic [NSRC-1:0]   match, haz;
  logic [SW-1:0]     match_k   [NSRC];
  logic [SW-1:0]     match_rdy [NSRC];
  logic              mdu_stall;

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      match[i]     = 1'b0;
      match_k[i]   = '0;
      match_rdy[i] = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
        if (v_q[k] && src_use[i] && (src_reg[i*RW +: RW] != '0) &&
            (dst_q[k] == src_reg[i*RW +: RW])) begin
          match[i]     = 1'b1;
          match_k[i]   = SW'(k);
          match_rdy[i] = rdy_q[k];
        end
      end
      haz[i] = match[i] &&
               (int'(match_rdy[i]) > int'(match_k[i]) + int'(src_need_e[i]));
    end
  end

  assign stall = ((|haz) | mdu_stall) & ~flush;

  always_comb begin
    fwd_sel_d   = '0;
    fwd_sel_e_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (match[i] && !src_need_e[i] && (match_rdy[i] <= match_k[i]))
        fwd_sel_d[i*SW +: SW] = match_k[i];
      // A producer in the last stage has retired; the write-through file supplies it.
      if (!stall && !flush && match[i] && src_need_e[i] && (int'(match_k[i]) < NSTAGE))
        fwd_sel_e_d[i*SW +: SW] = match_k[i] + SW'(1);
    end
  end

  assign v1_d = iss_we & (iss_dst != '0) & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        v_q[k]   <= 1'b0;
        dst_q[k] <= '0;
        rdy_q[k] <= '0;
      end
      fwd_sel_e_q <= '0;
    end else begin
      v_q[1]   <= v1_d;
      dst_q[1] <= iss_dst;
      rdy_q[1] <= iss_rdy;
      for (int k = 2; k <= NSTAGE; k++) begin
        v_q[k]   <= v_q[k-1];
        dst_q[k] <= dst_q[k-1];
        rdy_q[k] <= rdy_q[k-1];
      end
      fwd_sel_e_q <= fwd_sel_e_d;
    end
  end

  assign fwd_sel_e = fwd_sel_e_q;

`ifdef FWD_MDU_EN
  localparam int CW = $clog2(MDU_LAT + 1);
  logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_start && !stall && !flush)
      mdu_cnt_d = CW'(MDU_LAT);
    else if (mdu_cnt_q != '0)
      mdu_cnt_d = mdu_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdu_cnt_q <= '0;
    else        mdu_cnt_q <= mdu_cnt_d;
  end

  assign mdu_busy  = (mdu_cnt_q != '0);
  assign mdu_stall = (hilo_use | mdu_start) & mdu_busy;
`else
  localparam int UNUSED_MDU_LAT = MDU_LAT;
  logic unused_mdu;
  assign unused_mdu = hilo_use ^ mdu_start;
  assign mdu_busy   = 1'b0;
  assign mdu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed bench for fwd_scoreboard against an in-flight producer list model.
module tb_fwd_scoreboard;
  localparam int NSTAGE = 3, NSRC = 2, RW = 5, SW = 2, MDU_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSRC*RW-1:0] src_reg = '0;
  logic [NSRC-1:0] src_use = '0, src_need_e = '0;
  logic iss_we = 1'b0;
  logic [RW-1:0] iss_dst = '0;
  logic [SW-1:0] iss_rdy = '0;
  logic flush = 1'b0, hilo_use = 1'b0, mdu_start = 1'b0;
  logic [NSRC*SW-1:0] fwd_sel_d, fwd_sel_e;
  logic stall, mdu_busy;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NSTAGE(NSTAGE), .NSRC(NSRC), .RW(RW), .SW(SW), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .src_reg(src_reg), .src_use(src_use), .src_need_e(src_need_e),
    .iss_we(iss_we), .iss_dst(iss_dst), .iss_rdy(iss_rdy), .flush(flush),
    .hilo_use(hilo_use), .mdu_start(mdu_start), .fwd_sel_d(fwd_sel_d),
    .fwd_sel_e(fwd_sel_e), .stall(stall), .mdu_busy(mdu_busy));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: every accepted writer is a record aging one stage per cycle until it retires.
  typedef struct { int dst; int rdy; int age; } prod_t;
  prod_t inflight[$];
  int m_cnt = 0;

  int obs_stall, obs_busy;
  int obs_seld [NSRC];
  int obs_sele [NSRC];

  task automatic model_clear();
    inflight.delete();
    m_cnt = 0;
  endtask

  task automatic step(input int s0, input int s1, input int use_v, input int need_v,
                      input int we, input int dst, input int rdy, input int fl,
                      input int hu, input int ms);
    int  srcs [NSRC];
    int  exp_seld [NSRC];
    int  exp_sele [NSRC];
    bit  any_haz, mstall, exp_stall, accepted;
    srcs[0] = s0; srcs[1] = s1;
    @(negedge clk);
    src_reg    = {RW'(s1), RW'(s0)};
    src_use    = NSRC'(use_v);
    src_need_e = NSRC'(need_v);
    iss_we     = we[0];
    iss_dst    = RW'(dst);
    iss_rdy    = SW'(rdy);
    flush      = fl[0];
    hilo_use   = hu[0];
    mdu_start  = ms[0];
    #1;
    any_haz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int best;
      int brdy;
      bit need;
      best = 0; brdy = 0;
      need = need_v[i];
      if (use_v[i] && srcs[i] != 0)
        foreach (inflight[j])
          if (inflight[j].dst == srcs[i] && (best == 0 || inflight[j].age < best)) begin
            best = inflight[j].age;
            brdy = inflight[j].rdy;
          end
      exp_seld[i] = (best != 0 && !need && brdy <= best) ? best : 0;
      exp_sele[i] = (best != 0 && need && best + 1 <= NSTAGE) ? best + 1 : 0;
      if (best != 0 && brdy > best + int'(need)) any_haz = 1'b1;
    end
`ifdef FWD_MDU_EN
    mstall = (hu != 0 || ms != 0) && m_cnt != 0;
`else
    mstall = 1'b0;
`endif
    exp_stall = (any_haz || mstall) && fl == 0;
    obs_stall = int'(stall);
    obs_busy  = int'(mdu_busy);
    chk("stall", obs_stall, int'(exp_stall));
    chk("mdu_busy", obs_busy, int'(m_cnt != 0));
    for (int i = 0; i < NSRC; i++) begin
      obs_seld[i] = int'(fwd_sel_d[i*SW +: SW]);
      chk($sformatf("fwd_sel_d%0d", i), obs_seld[i], exp_seld[i]);
      if (exp_stall || fl != 0) exp_sele[i] = 0;
    end
    accepted = we != 0 && dst != 0 && !exp_stall && fl == 0;
    @(posedge clk);
    #1;
    foreach (inflight[j]) inflight[j].age++;
    for (int j = inflight.size() - 1; j >= 0; j--)
      if (inflight[j].age > NSTAGE) inflight.delete(j);
    if (accepted) inflight.push_back('{dst, rdy, 1});
`ifdef FWD_MDU_EN
    if (ms != 0 && !exp_stall && fl == 0) m_cnt = MDU_LAT;
    else if (m_cnt > 0) m_cnt--;
`endif
    for (int i = 0; i < NSRC; i++) begin
      obs_sele[i] = int'(fwd_sel_e[i*SW +: SW]);
      chk($sformatf("fwd_sel_e%0d", i), obs_sele[i], exp_sele[i]);
    end
  endtask

  task automatic nop(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_busy"}, int'(mdu_busy), 0);
    chk({tag, "_sele"}, int'(fwd_sel_e), 0);
  endtask

  initial begin
    #12;
    check_reset("rst");
    chk("rst_seld", int'(fwd_sel_d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();

    // ALU -> ALU, back to back and with one instruction between
    step(0, 0, 0, 0, 1, 3, 2, 0, 0, 0);
    step(3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("alu_alu_stall", obs_stall, 0);
    chk("alu_alu_sele", obs_sele[0], 2);
    nop(3);
    step(0, 0, 0, 0, 1, 3, 2, 0, 0, 0);
    nop(1);
    step(0, 3, 2, 2, 0, 0, 0, 0, 0, 0);
    chk("alu_gap_sele", obs_sele[1], 3);
    nop(3);
    // load-use
    step(0, 0, 0, 0, 1, 5, 3, 0, 0, 0);
    step(5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("ld_use_stall1", obs_stall, 1);
    step(5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("ld_use_stall2", obs_stall, 0);
    chk("ld_use_sele", obs_sele[0], 3);
    nop(3);
    // branch after ALU, then after load
    step(0, 0, 0, 0, 1, 4, 2, 0, 0, 0);
    step(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_alu_stall", obs_stall, 1);
    step(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_alu_seld", obs_seld[0], 2);
    nop(3);
    step(0, 0, 0, 0, 1, 4, 3, 0, 0, 0);
    step(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_ld_stall1", obs_stall, 1);
    step(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_ld_stall2", obs_stall, 1);
    step(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_ld_go", obs_stall, 0);
    chk("br_ld_seld", obs_seld[0], 3);
    nop(3);
    // jal -> jr, and $0 source
    step(0, 0, 0, 0, 1, 31, 1, 0, 0, 0);
    step(31, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("jr_stall", obs_stall, 0);
    chk("jr_seld", obs_seld[0], 1);
    chk("zero_seld", obs_seld[1], 0);
    nop(3);
    // youngest match wins
    step(0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    step(7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("youngest_seld", obs_seld[0], 1);
    nop(3);
    // flushed writer never enters
    step(0, 0, 0, 0, 1, 9, 1, 1, 0, 0);
    step(9, 9, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_seld", obs_seld[0], 0);
    chk("flush_stall", obs_stall, 0);
    nop(3);
`ifdef FWD_MDU_EN
    begin
      int stalls;
      stalls = 0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int j = 0; j < 8 && (j == 0 || obs_stall == 1); j++) begin
        step(0, 0, 0, 0, 1, 2, 2, 0, 1, 0);
        stalls += obs_stall;
      end
      chk("mdu_stall_cycles", stalls, MDU_LAT);
      chk("mdu_busy_after", obs_busy, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("mdu_mid_stall", obs_stall, 1);
      rst_n = 1'b0;
      #1;
      check_reset("mdu_rst");
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      nop(1);
    end
`endif
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(1, 3), ($urandom_range(0, 7) == 0) ? 1 : 0,
           $urandom_range(0, 1), ($urandom_range(0, 5) == 0) ? 1 : 0);
      if (n == 200) begin
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
